// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: access-size encodings,
// FSM state encoding, memory-map defaults and the alignment helper.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'b00,
    SIZE_HALF    = 2'b01,
    SIZE_WORD    = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_RESP = 2'b11
  } state_e;

  localparam logic [31:0] DEFAULT_DATA_BASE    = 32'h1001_0000;
  localparam int unsigned DEFAULT_MEMORY_DEPTH = 2048;

  // Half accesses need addr[0]==0, word accesses need addr[1:0]==0.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (size)
      SIZE_HALF: mis = addr_lo[0];
      SIZE_WORD: mis = (addr_lo != 2'b00);
      default:   mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Bus interfaces of the load/store unit.
//
// load_store_unit_if     : CPU request / response channel.
//   req_*   : a request transfers on the posedge where req_valid & req_ready
//             are both high; the CPU keeps req_* stable while req_valid is
//             high and req_ready is low. resp_* has no backpressure:
//             resp_valid is a single-cycle pulse, resp_rdata holds until the
//             next response.
//   modport master = CPU side, slave = load/store unit.
//
// load_store_unit_mem_if : word-wide data-memory port.
//   mem_address (word aligned), mem_write_data, mem_read, mem_write driven by
//   the unit; mem_read_data returned combinationally by the memory.
//   modport master = load/store unit, slave = memory.
interface load_store_unit_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_address;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic                  resp_error;
  logic [DATA_WIDTH-1:0] resp_rdata;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_address, req_wdata,
    input  req_ready, resp_valid, resp_error, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_address, req_wdata,
    output req_ready, resp_valid, resp_error, resp_rdata
  );
endinterface

interface load_store_unit_mem_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) ();
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_write_data;
  logic                  mem_read;
  logic                  mem_write;
  logic [DATA_WIDTH-1:0] mem_read_data;

  modport master (
    output mem_address, mem_write_data, mem_read, mem_write,
    input  mem_read_data
  );

  modport slave (
    input  mem_address, mem_write_data, mem_read, mem_write,
    output mem_read_data
  );
endinterface

// File: rtl/load_store_unit_byte_lane_unit.sv
// byte_lane_unit: combinational lane steering for sub-word accesses.
//   store_word_i  : word previously read from memory (merge base)
//   store_data_i  : right-justified store data
//   size_i        : access size (size_e encoding)
//   addr_lo_i     : byte address bits [1:0]
//   load_word_i   : word read from memory for a load
//   unsigned_i    : 1 = zero-extend, 0 = sign-extend
//   merged_o      : word with the addressed lane(s) replaced
//   load_result_o : extracted and extended load value
// Lanes are little-endian: byte k = bits [8k+7:8k], half h = bits [16h+15:16h].
module byte_lane_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] store_word_i,
  input  logic [DATA_WIDTH-1:0] store_data_i,
  input  logic [1:0]            size_i,
  input  logic [1:0]            addr_lo_i,
  input  logic [DATA_WIDTH-1:0] load_word_i,
  input  logic                  unsigned_i,
  output logic [DATA_WIDTH-1:0] merged_o,
  output logic [DATA_WIDTH-1:0] load_result_o
);

  logic [4:0]  byte_sel;
  logic [4:0]  half_sel;
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  assign byte_sel = {addr_lo_i, 3'b000};
  assign half_sel = {addr_lo_i[1], 4'b0000};

  always_comb begin
    merged_o = store_word_i;
    case (size_i)
      SIZE_BYTE: merged_o[byte_sel +: 8]  = store_data_i[7:0];
      SIZE_HALF: merged_o[half_sel +: 16] = store_data_i[15:0];
      default:   merged_o = store_data_i;
    endcase
  end

  always_comb begin
    load_byte     = load_word_i[byte_sel +: 8];
    load_half     = load_word_i[half_sel +: 16];
    load_result_o = load_word_i;
    case (size_i)
      SIZE_BYTE: load_result_o = unsigned_i ? {{(DATA_WIDTH-8){1'b0}}, load_byte}
                                            : {{(DATA_WIDTH-8){load_byte[7]}}, load_byte};
      SIZE_HALF: load_result_o = unsigned_i ? {{(DATA_WIDTH-16){1'b0}}, load_half}
                                            : {{(DATA_WIDTH-16){load_half[15]}}, load_half};
      default:   load_result_o = load_word_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the word-only data memory.
// Accepts one byte/half/word load or store at a time, performs sub-word
// stores by read-modify-write and reports misaligned, illegal-size and
// out-of-range accesses as an error response without touching memory.
//   clk, reset : clock, synchronous active-high reset
//   cpu        : request/response channel (slave side)
//   mem        : data-memory port (master side)
//   dbg_state  : current FSM state
// Sequences after acceptance at edge N:
//   load             RD(N+1) -> RESP(N+2)
//   word store       WR(N+1) -> RESP(N+2)
//   byte/half store  RD(N+1) -> WR(N+2) -> RESP(N+3)
//   error            RESP(N+1)
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] DATA_BASE    = DEFAULT_DATA_BASE,
  parameter int unsigned           MEMORY_DEPTH = DEFAULT_MEMORY_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  load_store_unit_if.slave      cpu,
  load_store_unit_mem_if.master mem,
  output state_e                dbg_state
);

  // One extra bit so the end-of-memory limit cannot wrap.
  localparam logic [ADDR_WIDTH:0] BASE_EXT  = {1'b0, DATA_BASE};
  localparam logic [ADDR_WIDTH:0] LIMIT_EXT = BASE_EXT + (ADDR_WIDTH+1)'(64'(MEMORY_DEPTH) * 64'd4);

  state_e                state_q, state_d;
  logic                  write_q, write_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  accept;
  logic                  req_err;
  logic                  out_of_range;
  logic [ADDR_WIDTH:0]   req_addr_ext;
  logic [DATA_WIDTH-1:0] merged_word;
  logic [DATA_WIDTH-1:0] load_result;

  assign accept       = cpu.req_valid & cpu.req_ready;
  assign req_addr_ext = {1'b0, cpu.req_address};
  assign out_of_range = (req_addr_ext < BASE_EXT) || (req_addr_ext >= LIMIT_EXT);
  assign req_err      = (cpu.req_size == SIZE_ILLEGAL)
                      | is_misaligned(cpu.req_size, cpu.req_address[1:0])
                      | out_of_range;

  byte_lane_unit #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lanes (
    .store_word_i  (word_q),
    .store_data_i  (wdata_q),
    .size_i        (size_q),
    .addr_lo_i     (addr_q[1:0]),
    .load_word_i   (mem.mem_read_data),
    .unsigned_i    (uns_q),
    .merged_o      (merged_word),
    .load_result_o (load_result)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      write_q <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      word_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_err)                                            state_d = ST_RESP;
          else if (cpu.req_write && (cpu.req_size == SIZE_WORD))  state_d = ST_WR;
          else                                                    state_d = ST_RD;
        end
      end
      // RD precedes WR only for sub-word stores; word stores skip it.
      ST_RD:   state_d = write_q ? ST_WR : ST_RESP;
      ST_WR:   state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request capture, read-word capture and response data.
  always_comb begin
    write_d = write_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    word_d  = word_q;
    rdata_d = rdata_q;
    if ((state_q == ST_IDLE) && accept) begin
      write_d = cpu.req_write;
      size_d  = cpu.req_size;
      uns_d   = cpu.req_unsigned;
      addr_d  = cpu.req_address;
      wdata_d = cpu.req_wdata;
      err_d   = req_err;
      if (req_err) rdata_d = '0;
    end
    if (state_q == ST_RD) begin
      word_d = mem.mem_read_data;
      if (!write_q) rdata_d = load_result;
    end
    if (state_q == ST_WR) rdata_d = '0;
  end

  // Outputs. Reset gates everything combinationally so an in-flight write
  // or response in the reset cycle is suppressed.
  always_comb begin
    cpu.req_ready      = (state_q == ST_IDLE) & ~reset;
    cpu.resp_valid     = (state_q == ST_RESP) & ~reset;
    cpu.resp_error     = (state_q == ST_RESP) & err_q & ~reset;
    cpu.resp_rdata     = rdata_q;
    mem.mem_read       = (state_q == ST_RD) & ~reset;
    mem.mem_write      = (state_q == ST_WR) & ~reset;
    mem.mem_address    = '0;
    mem.mem_write_data = '0;
    if ((state_q == ST_RD) || (state_q == ST_WR)) begin
      mem.mem_address = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    end
    if (state_q == ST_WR) begin
      mem.mem_write_data = (size_q == SIZE_WORD) ? wdata_q : merged_word;
    end
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic   clk;
  logic   reset;
  state_e dbg_state;
  int     checks;
  int     errors;

  load_store_unit_if     #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) cpu_if ();
  load_store_unit_mem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) mem_if ();

  load_store_unit #(
    .DATA_WIDTH   (32),
    .ADDR_WIDTH   (32),
    .DATA_BASE    (32'h1001_0000),
    .MEMORY_DEPTH (2048)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu       (cpu_if),
    .mem       (mem_if),
    .dbg_state (dbg_state)
  );

  // Clock / reset.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Behavioural data memory: combinational read gated by mem_read, write on posedge.
  logic [31:0] mem_model [0:2047];
  logic [31:0] mem_off;
  logic [10:0] mem_idx;
  assign mem_off = mem_if.mem_address - 32'h1001_0000;
  assign mem_idx = mem_off[12:2];
  assign mem_if.mem_read_data = mem_if.mem_read ? mem_model[mem_idx] : 32'h0;
  always @(posedge clk) if (mem_if.mem_write) mem_model[mem_idx] <= mem_if.mem_write_data;

  // Driver: issue one request from IDLE and trace the next 6 cycles.
  // Masks have bit k set when the signal was high in cycle N+k.
  task automatic run_req(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output int lat, output logic [31:0] rdata, output logic err,
                         output int rd_mask, output int wr_mask, output int n_resp,
                         output logic [31:0] wdata_seen);
    @(posedge clk); #1;
    cpu_if.req_valid    = 1'b1;
    cpu_if.req_write    = wr;
    cpu_if.req_size     = sz;
    cpu_if.req_unsigned = uns;
    cpu_if.req_address  = addr;
    cpu_if.req_wdata    = wd;
    @(posedge clk); #1;
    cpu_if.req_valid = 1'b0;
    cpu_if.req_wdata = 32'h0;
    lat = 0; rdata = 32'h0; err = 1'b0; rd_mask = 0; wr_mask = 0; n_resp = 0; wdata_seen = 32'h0;
    for (int k = 1; k <= 6; k++) begin
      if (mem_if.mem_read) rd_mask |= (1 << k);
      if (mem_if.mem_write) begin
        wr_mask |= (1 << k);
        wdata_seen = mem_if.mem_write_data;
      end
      if (cpu_if.resp_valid) begin
        n_resp++;
        if (lat == 0) begin
          lat = k; rdata = cpu_if.resp_rdata; err = cpu_if.resp_error;
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (cpu_if.req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", cpu_if.req_ready); end
    checks++; if (cpu_if.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b want 0", cpu_if.resp_valid); end
    checks++; if (cpu_if.resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", cpu_if.resp_rdata); end
    checks++; if ({mem_if.mem_read, mem_if.mem_write} !== 2'b00) begin errors++; $display("FAIL reset_mem_rw got %b want 00", {mem_if.mem_read, mem_if.mem_write}); end
    checks++; if (mem_if.mem_address !== 32'h0) begin errors++; $display("FAIL reset_mem_address got %h want 0", mem_if.mem_address); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d want IDLE", dbg_state); end
    reset = 1'b0;
    #1;
    checks++; if (cpu_if.req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got %b want 1", cpu_if.req_ready); end
  endtask

  task automatic test_word_store_load();
    int lat, rdm, wrm, nr; logic [31:0] rd, ws; logic er;
    run_req(1'b1, SIZE_WORD, 1'b0, 32'h1001_0004, 32'hDEAD_BEEF, lat, rd, er, rdm, wrm, nr, ws);
    checks++; if (lat !== 2 || nr !== 1) begin errors++; $display("FAIL sw_latency got lat=%0d n=%0d want 2/1", lat, nr); end
    checks++; if (wrm !== 2 || rdm !== 0) begin errors++; $display("FAIL sw_pulses got wr=%0h rd=%0h want 2/0", wrm, rdm); end
    checks++; if (ws !== 32'hDEAD_BEEF || rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL sw_data got w=%h r=%h e=%b want deadbeef/0/0", ws, rd, er); end
    run_req(1'b0, SIZE_WORD, 1'b0, 32'h1001_0004, 32'h0, lat, rd, er, rdm, wrm, nr, ws);
    checks++; if (lat !== 2 || rdm !== 2 || wrm !== 0) begin errors++; $display("FAIL lw_timing got lat=%0d rd=%0h wr=%0h want 2/2/0", lat, rdm, wrm); end
    checks++; if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin errors++; $display("FAIL lw_data got %h e=%b want deadbeef/0", rd, er); end
  endtask

  task automatic test_byte_access();
    int lat, rdm, wrm, nr; logic [31:0] rd, ws; logic er;
    run_req(1'b1, SIZE_WORD, 1'b0, 32'h1001_0008, 32'h1122_3344, lat, rd, er, rdm, wrm, nr, ws);
    run_req(1'b1, SIZE_BYTE, 1'b0, 32'h1001_000A, 32'h0000_00AA, lat, rd, er, rdm, wrm, nr, ws);
    checks++; if (lat !== 3 || nr !== 1) begin errors++; $display("FAIL sb_latency got lat=%0d n=%0d want 3/1", lat, nr); end
    checks++; if (rdm !== 2 || wrm !== 4) begin errors++; $display("FAIL sb_pulses got rd=%0h wr=%0h want 2/4", rdm, wrm); end
    checks++; if (ws !== 32'h11AA_3344) begin errors++; $display("FAIL sb_merge got %h want 11aa3344", ws); end
    run_req(1'b0, SIZE_BYTE, 1'b0, 32'h1001_000A, 32'h0, lat, rd, er, rdm, wrm, nr, ws);
    checks++; if (rd !== 32'hFFFF_FFAA) begin errors++; $display("FAIL lb got %h want ffffffaa", rd); end
    run_req(1'b0, SIZE_BYTE, 1'b1, 32'h1001_000A, 32'h0, lat, rd, er, rdm, wrm, nr, ws);
    checks++; if (rd !== 32'h0000_00AA) begin errors++; $display("FAIL lbu got %h want 000000aa", rd); end
    run_req(1'b0, SIZE_BYTE, 1'b1, 32'h1001_0008, 32'h0, lat, rd, er, rdm, wrm, nr, ws);
    checks++; if (rd !== 32'h0000_0044) begin errors++; $display("FAIL lbu_lane0 got %h want 00000044", rd); end
  endtask

  task automatic test_half_access();
    int lat, rdm, wrm, nr; logic [31:0] rd, ws; logic er;
    run_req(1'b1, SIZE_WORD, 1'b0, 32'h1001_0004, 32'h0, lat, rd, er, rdm, wrm, nr, ws);
    run_req(1'b1, SIZE_HALF, 1'b0, 32'h1001_0006, 32'h0000_8001, lat, rd, er, rdm, wrm, nr, ws);
    checks++; if (lat !== 3 || ws !== 32'h8001_0000) begin errors++; $display("FAIL sh got lat=%0d w=%h want 3/80010000", lat, ws); end
    run_req(1'b0, SIZE_HALF, 1'b0, 32'h1001_0006, 32'h0, lat, rd, er, rdm, wrm, nr, ws);
    checks++; if (rd !== 32'hFFFF_8001) begin errors++; $display("FAIL lh got %h want ffff8001", rd); end
    run_req(1'b0, SIZE_HALF, 1'b1, 32'h1001_0006, 32'h0, lat, rd, er, rdm, wrm, nr, ws);
    checks++; if (rd !== 32'h0000_8001) begin errors++; $display("FAIL lhu got %h want 00008001", rd); end
    run_req(1'b0, SIZE_BYTE, 1'b0, 32'h1001_0007, 32'h0, lat, rd, er, rdm, wrm, nr, ws);
    checks++; if (rd !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_lane3 got %h want ffffff80", rd); end
  endtask

  task automatic test_errors();
    logic [1:0]  sz_t   [5] = '{SIZE_WORD, SIZE_HALF, SIZE_ILLEGAL, SIZE_WORD, SIZE_WORD};
    logic [31:0] addr_t [5] = '{32'h1001_0002, 32'h1001_0001, 32'h1001_0000, 32'h1000_FFFC, 32'h1001_2000};
    int lat, rdm, wrm, nr; logic [31:0] rd, ws; logic er;
    for (int i = 0; i < 5; i++) begin
      run_req(1'b0, sz_t[i], 1'b0, addr_t[i], 32'h0, lat, rd, er, rdm, wrm, nr, ws);
      checks++;
      if (lat !== 1 || er !== 1'b1 || rd !== 32'h0 || rdm !== 0 || wrm !== 0 || nr !== 1) begin
        errors++;
        $display("FAIL err_case%0d got lat=%0d e=%b r=%h rd=%0h wr=%0h n=%0d want 1/1/0/0/0/1", i, lat, er, rd, rdm, wrm, nr);
      end
    end
    // A store with an error must not write either.
    run_req(1'b1, SIZE_WORD, 1'b0, 32'h1001_2000, 32'h1234_5678, lat, rd, er, rdm, wrm, nr, ws);
    checks++; if (wrm !== 0 || er !== 1'b1 || lat !== 1) begin errors++; $display("FAIL err_store got wr=%0h e=%b lat=%0d want 0/1/1", wrm, er, lat); end
  endtask

  task automatic test_range_edge();
    int lat, rdm, wrm, nr; logic [31:0] rd, ws; logic er;
    run_req(1'b1, SIZE_WORD, 1'b0, 32'h1001_1FFC, 32'hCAFE_F00D, lat, rd, er, rdm, wrm, nr, ws);
    run_req(1'b0, SIZE_WORD, 1'b0, 32'h1001_1FFC, 32'h0, lat, rd, er, rdm, wrm, nr, ws);
    checks++; if (rd !== 32'hCAFE_F00D || er !== 1'b0) begin errors++; $display("FAIL last_word got %h e=%b want cafef00d/0", rd, er); end
  endtask

  task automatic test_reset_mid_write();
    int lat, rdm, wrm, nr, resp_cnt; logic [31:0] rd, ws; logic er;
    run_req(1'b1, SIZE_WORD, 1'b0, 32'h1001_000C, 32'h5566_7788, lat, rd, er, rdm, wrm, nr, ws);
    @(posedge clk); #1;
    cpu_if.req_valid = 1'b1; cpu_if.req_write = 1'b1; cpu_if.req_size = SIZE_BYTE;
    cpu_if.req_unsigned = 1'b0; cpu_if.req_address = 32'h1001_000C; cpu_if.req_wdata = 32'h99;
    @(posedge clk); #1;
    cpu_if.req_valid = 1'b0;
    resp_cnt = 0;
    if (cpu_if.resp_valid) resp_cnt++;
    @(posedge clk); #1;
    checks++; if (mem_if.mem_write !== 1'b1) begin errors++; $display("FAIL wr_cycle_write got %b want 1", mem_if.mem_write); end
    reset = 1'b1;
    #1;
    checks++; if (mem_if.mem_write !== 1'b0) begin errors++; $display("FAIL reset_gates_write got %b want 0", mem_if.mem_write); end
    @(posedge clk); #1;
    checks++; if (cpu_if.req_ready !== 1'b0 || dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_mid got ready=%b st=%0d want 0/IDLE", cpu_if.req_ready, dbg_state); end
    reset = 1'b0;
    #1;
    checks++; if (cpu_if.req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_mid_reset got %b want 1", cpu_if.req_ready); end
    repeat (4) begin
      if (cpu_if.resp_valid) resp_cnt++;
      @(posedge clk); #1;
    end
    checks++; if (resp_cnt !== 0) begin errors++; $display("FAIL dropped_resp got %0d want 0", resp_cnt); end
    run_req(1'b0, SIZE_WORD, 1'b0, 32'h1001_000C, 32'h0, lat, rd, er, rdm, wrm, nr, ws);
    checks++; if (rd !== 32'h5566_7788) begin errors++; $display("FAIL write_suppressed got %h want 55667788", rd); end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  sz_t   [3] = '{SIZE_WORD, SIZE_BYTE, SIZE_HALF};
    logic        un_t   [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] addr_t [3] = '{32'h1001_0010, 32'h1001_0015, 32'h1001_001A};
    logic [31:0] exp_q [$];
    logic [31:0] exp_v;
    int lat, rdm, wrm, nr; logic [31:0] rd, ws; logic er;
    int accepted, since, pulses;
    logic will;
    run_req(1'b1, SIZE_WORD, 1'b0, 32'h1001_0010, 32'h0102_0304, lat, rd, er, rdm, wrm, nr, ws);
    run_req(1'b1, SIZE_WORD, 1'b0, 32'h1001_0014, 32'h0A0B_0C8D, lat, rd, er, rdm, wrm, nr, ws);
    run_req(1'b1, SIZE_WORD, 1'b0, 32'h1001_0018, 32'h8765_4321, lat, rd, er, rdm, wrm, nr, ws);
    exp_q.push_back(32'h0102_0304);
    exp_q.push_back(32'h0000_000C);
    exp_q.push_back(32'hFFFF_8765);
    @(posedge clk); #1;
    cpu_if.req_valid = 1'b1; cpu_if.req_write = 1'b0; cpu_if.req_wdata = 32'h0;
    cpu_if.req_size = sz_t[0]; cpu_if.req_unsigned = un_t[0]; cpu_if.req_address = addr_t[0];
    accepted = 0; since = 0; pulses = 0;
    will = cpu_if.req_ready;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (will) begin
        accepted++; since = 1; will = 1'b0;
        if (accepted < 3) begin
          cpu_if.req_size = sz_t[accepted]; cpu_if.req_unsigned = un_t[accepted];
          cpu_if.req_address = addr_t[accepted];
        end else cpu_if.req_valid = 1'b0;
      end else if (since != 0) since++;
      if (cpu_if.resp_valid) pulses++;
      if (since == 1 || since == 2) begin
        checks++; if (cpu_if.req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_busy acc=%0d got %b want 0", accepted, cpu_if.req_ready); end
      end
      if (since == 2) begin
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
        checks++; if (cpu_if.resp_valid !== 1'b1 || cpu_if.resp_rdata !== exp_v) begin errors++; $display("FAIL b2b_resp acc=%0d got v=%b d=%h want 1/%h", accepted, cpu_if.resp_valid, cpu_if.resp_rdata, exp_v); end
      end
      if (since == 3) begin
        checks++; if (cpu_if.resp_valid !== 1'b0 || cpu_if.req_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle acc=%0d got v=%b rdy=%b want 0/1", accepted, cpu_if.resp_valid, cpu_if.req_ready); end
      end
      if (cpu_if.req_valid && cpu_if.req_ready) will = 1'b1;
      if (accepted == 3 && since >= 3) break;
    end
    cpu_if.req_valid = 1'b0;
    checks++; if (accepted !== 3 || pulses !== 3) begin errors++; $display("FAIL b2b_count got acc=%0d resp=%0d want 3/3", accepted, pulses); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    cpu_if.req_valid = 1'b0; cpu_if.req_write = 1'b0; cpu_if.req_size = 2'b00;
    cpu_if.req_unsigned = 1'b0; cpu_if.req_address = 32'h0; cpu_if.req_wdata = 32'h0;
    test_reset();
    test_word_store_load();
    test_byte_access();
    test_half_access();
    test_errors();
    test_range_edge();
    test_reset_mid_write();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
